pos_div_shift_sub: RTL and testbench



---
 rtl/pos_div_shift_sub_if.sv | 26 ++
 rtl/pos_div_shift_sub.sv | 146 ++++++++++++++
 tb/tb_pos_div_shift_sub.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pos_div_shift_sub_if.sv
// Operand/result handshake bundle for pos_div_shift_sub.
// master drives operands and out_ready; slave is the divider.
interface pos_div_shift_sub_if #(
   parameter int unsigned N_BITS_N = 16,
   parameter int unsigned N_BITS_D = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [N_BITS_N-1:0] n;
   logic [N_BITS_D-1:0] d;
   logic                out_valid;
   logic                out_ready;
   logic [N_BITS_N-1:0] q;
   logic [N_BITS_D-1:0] r;
   logic                dbz;

   modport master (
      output in_valid, n, d, out_ready,
      input  in_ready, out_valid, q, r, dbz
   );

   modport slave (
      input  in_valid, n, d, out_ready,
      output in_ready, out_valid, q, r, dbz
   );
endinterface

// File: rtl/pos_div_shift_sub.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, valid/ready on both sides.
// Optional macro POS_DIV_ZERO_CHECK_EN: d == 0 skips iteration, goes straight to DONE with dbz set.
module pos_div_shift_sub #(
   parameter int unsigned N_BITS_N = 16,
   parameter int unsigned N_BITS_D = 8
) (
   input logic               clk,
   input logic               rst_n,
   pos_div_shift_sub_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(N_BITS_N + 1);
   localparam int unsigned T_W   = N_BITS_D + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [N_BITS_N-1:0] qreg;
   // Only the low N_BITS_D bits of the partial remainder are ever observed or fed back.
   logic [N_BITS_D-1:0] p;
   logic [N_BITS_D-1:0] d_q;
   logic [CNT_W-1:0]    cnt;

   logic                in_ready_c;
   logic                out_valid_c;
   logic                load_c;
   logic                step_c;
   logic [T_W-1:0]      t_c;
   logic                ge_c;
   logic [N_BITS_D-1:0] p_nxt_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
`ifdef POS_DIV_ZERO_CHECK_EN
               state_nxt = (bus.d == '0) ? DONE : RUN;
`else
               state_nxt = RUN;
`endif
            end
         end
         RUN: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      load_c      = 1'b0;
      step_c      = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            load_c     = bus.in_valid;
         end
         RUN:     step_c      = 1'b1;
         DONE:    out_valid_c = 1'b1;
         default: ;
      endcase
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      t_c     = {p, qreg[N_BITS_N-1]};
      ge_c    = (t_c >= {1'b0, d_q});
      p_nxt_c = ge_c ? N_BITS_D'(t_c - {1'b0, d_q}) : t_c[N_BITS_D-1:0];
   end

`ifdef POS_DIV_ZERO_CHECK_EN
   logic dbz_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbz_q <= 1'b0;
      end else if (load_c) begin
         dbz_q <= (bus.d == '0);
      end
   end

   assign bus.dbz = dbz_q;
`else
   assign bus.dbz = 1'b0;
`endif

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qreg <= '0;
         p    <= '0;
         d_q  <= '0;
         cnt  <= '0;
      end else if (load_c) begin
         d_q <= bus.d;
         cnt <= CNT_W'(N_BITS_N);
`ifdef POS_DIV_ZERO_CHECK_EN
         if (bus.d == '0) begin
            qreg <= '1;
            p    <= N_BITS_D'(bus.n);
         end else begin
            qreg <= bus.n;
            p    <= '0;
         end
`else
         qreg <= bus.n;
         p    <= '0;
`endif
      end else if (step_c) begin
         qreg <= N_BITS_N'({qreg, ge_c});
         p    <= p_nxt_c;
         cnt  <= cnt - CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.q         = qreg;
   assign bus.r         = p;
endmodule

// File: tb/tb_pos_div_shift_sub.sv
// Self-checking bench for pos_div_shift_sub (N_BITS_N=16, N_BITS_D=8).
// Arithmetic model (/ and %) plus a latency countdown, checked every cycle, with literal spot checks.
module tb_pos_div_shift_sub;
   localparam int unsigned NN = 16;
   localparam int unsigned ND = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pos_div_shift_sub_if #(.N_BITS_N(NN), .N_BITS_D(ND)) bus ();

   pos_div_shift_sub #(.N_BITS_N(NN), .N_BITS_D(ND)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 = idle, 1 = computing, 2 = result pending
   int          m_phase = 0;
   int          m_left  = 0;
   logic [15:0] e_q     = '0;
   logic [7:0]  e_r     = '0;
   logic        e_dbz   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_left  <= 0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
               if (bus.d == 8'd0) begin
                  e_q <= 16'hFFFF;
                  e_r <= bus.n[7:0];
`ifdef POS_DIV_ZERO_CHECK_EN
                  e_dbz   <= 1'b1;
                  m_phase <= 2;
`else
                  e_dbz   <= 1'b0;
                  m_phase <= 1;
                  m_left  <= NN;
`endif
               end else begin
                  e_q     <= 16'(bus.n / bus.d);
                  e_r     <= 8'(bus.n % bus.d);
                  e_dbz   <= 1'b0;
                  m_phase <= 1;
                  m_left  <= NN;
               end
            end
            1: begin
               m_left <= m_left - 1;
               if (m_left == 1) m_phase <= 2;
            end
            default: if (bus.out_ready) m_phase <= 0;
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", bus.in_ready, m_phase == 0);
         check("out_valid", bus.out_valid, m_phase == 2);
         if (m_phase == 2) begin
            check("q", bus.q, e_q);
            check("r", bus.r, e_r);
            check("dbz", bus.dbz, e_dbz);
         end
`ifndef POS_DIV_ZERO_CHECK_EN
         check("dbz_tied", bus.dbz, 1'b0);
`endif
      end
   end

   task automatic accept(input logic [15:0] nv, input logic [7:0] dv, output int acc);
      bit got = 1'b0;
      bus.n        = nv;
      bus.d        = dv;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_wait", got, 1'b1);
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic wait_out(input int acc, output int lat);
      bit got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (k != 0 || !bus.out_valid) @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("result_wait", got, 1'b1);
      lat = cyc - acc;
   endtask

   task automatic run_op(input logic [15:0] nv, input logic [7:0] dv, input logic [15:0] xq,
                         input logic [7:0] xr, input logic xdbz, input int xlat);
      int acc;
      int lat;
      accept(nv, dv, acc);
      bus.in_valid = 1'b0;
      wait_out(acc, lat);
      check("latency", lat, xlat);
      check("lit_q", bus.q, xq);
      check("lit_r", bus.r, xr);
      check("lit_dbz", bus.dbz, xdbz);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_q", bus.q, 16'd0);
      check("rst_r", bus.r, 8'd0);
      check("rst_dbz", bus.dbz, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int lat;
      int a0;
      int a1;
      int a2;
      bus.in_valid  = 1'b0;
      bus.n         = '0;
      bus.d         = '0;
      bus.out_ready = 1'b0;
      #3;
      check_reset_vals();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;

      run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
      run_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16);
      run_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16);
`ifdef POS_DIV_ZERO_CHECK_EN
      run_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 0);
`else
      run_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b0, 16);
`endif

      // Backpressure: result held, new operands ignored
      bus.out_ready = 1'b0;
      accept(16'd300, 8'd13, acc);
      bus.in_valid = 1'b0;
      wait_out(acc, lat);
      check("bp_latency", lat, 16);
      for (int i = 0; i < 10; i++) begin
         check("bp_q", bus.q, 16'd23);
         check("bp_r", bus.r, 8'd1);
         check("bp_in_ready", bus.in_ready, 1'b0);
         check("bp_out_valid", bus.out_valid, 1'b1);
         bus.in_valid = i[0];
         bus.n        = 16'($urandom);
         bus.d        = 8'($urandom_range(1, 255));
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", bus.in_ready, 1'b1);
      check("bp_release_out_valid", bus.out_valid, 1'b0);

      // Reset in the middle of an operation
      accept(16'd40000, 8'd200, acc);
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      run_op(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, 16);

      // Back-to-back with in_valid held high
      bus.out_ready = 1'b1;
      accept(16'd1000, 8'd7, a0);
      accept(16'd65535, 8'd255, a1);
      accept(16'd300, 8'd13, a2);
      bus.in_valid = 1'b0;
      check("b2b_spacing_1", a1 - a0, 18);
      check("b2b_spacing_2", a2 - a1, 18);
      wait_out(a2, lat);
      check("b2b_latency", lat, 16);
      check("b2b_lit_q", bus.q, 16'd23);
      check("b2b_lit_r", bus.r, 8'd1);
      @(posedge clk);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
